// File: rtl/ysyx_25030093_ifu.sv
// Instruction fetch unit: one single-beat AXI4-Lite read per accepted PC,
// with misaligned, bus-error and timeout faults reported to decode.
module ysyx_25030093_ifu #(
    parameter int unsigned TIMEOUT    = 255,
    parameter bit          RESET_SKIP = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        pc_valid,
    output logic        pc_ready,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R_WAIT,
        DRAIN,
        OUT
    } state_e;

    localparam logic [15:0] CNT_MAX = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] araddr_q, araddr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;
    logic        skip_q, skip_d;
    logic        late_q, late_d;
    logic        ack_q, ack_d;
    logic        late_nxt, ack_nxt;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        araddr_d  = araddr_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        fault_d   = fault_q;
        cause_d   = cause_q;
        skip_d    = 1'b0;
        late_d    = late_q;
        ack_d     = ack_q;
        late_nxt  = late_q | rvalid;
        ack_nxt   = ack_q | inst_ready;
        unique case (state_q)
            IDLE: begin
                if (pc_valid && !skip_q) begin
                    inst_pc_d = pc;
                    if (pc[1:0] == 2'b00) begin
                        araddr_d = pc;
                        state_d  = AR;
                    end else begin
                        inst_d  = 32'h0;
                        fault_d = 1'b1;
                        cause_d = 2'b01;
                        state_d = OUT;
                    end
                end
            end
            AR: begin
                if (arready) begin
                    cnt_d   = 16'h0;
                    state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                // A beat arriving on the expiry cycle still completes normally.
                if (rvalid) begin
                    state_d = OUT;
                    if (rresp == 2'b00) begin
                        inst_d  = rdata;
                        fault_d = 1'b0;
                        cause_d = 2'b00;
                    end else begin
                        inst_d  = 32'h0;
                        fault_d = 1'b1;
                        cause_d = 2'b10;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    inst_d  = 32'h0;
                    fault_d = 1'b1;
                    cause_d = 2'b11;
                    late_d  = 1'b0;
                    ack_d   = 1'b0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + 16'h1;
                end
            end
            DRAIN: begin
                late_d = late_nxt;
                ack_d  = ack_nxt;
                if (late_nxt && ack_nxt) begin
                    state_d = IDLE;
                end
            end
            OUT: begin
                if (inst_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 16'h0;
            araddr_q  <= 32'h0;
            inst_q    <= 32'h0;
            inst_pc_q <= 32'h0;
            fault_q   <= 1'b0;
            cause_q   <= 2'b00;
            skip_q    <= RESET_SKIP;
            late_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            araddr_q  <= araddr_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            fault_q   <= fault_d;
            cause_q   <= cause_d;
            skip_q    <= skip_d;
            late_q    <= late_d;
            ack_q     <= ack_d;
        end
    end

    // Once decode has taken the timeout fault it is not offered again.
    assign pc_ready    = (state_q == IDLE) && !skip_q;
    assign arvalid     = (state_q == AR);
    assign rready      = (state_q == R_WAIT) || ((state_q == DRAIN) && !late_q);
    assign inst_valid  = (state_q == OUT) || ((state_q == DRAIN) && !ack_q);
    assign araddr      = araddr_q;
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign fault       = fault_q;
    assign fault_cause = cause_q;

endmodule

// File: tb/tb_ysyx_25030093_ifu.sv
// Randomized scoreboard bench for ysyx_25030093_ifu with an AXI slave
// model, a decode-side monitor and directed reset/latency scenarios.
module tb_ysyx_25030093_ifu;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        fault;
    logic [1:0]  fault_cause;

    ysyx_25030093_ifu #(
        .TIMEOUT   (TO),
        .RESET_SKIP(1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .pc_ready   (pc_ready),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .fault      (fault),
        .fault_cause(fault_cause)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
        logic [1:0]  cause;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          delay;
        logic [1:0]  resp;
        logic [31:0] data;
    } plan_t;

    exp_t  exp_q[$];
    plan_t plan_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    fast = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [67:0] act,
                       input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: what decode must see for one PC, given the bus behaviour.
    function automatic exp_t model(input logic [31:0] a, input int d,
                                   input logic [1:0] r, input logic [31:0] data);
        exp_t e;
        e.pc = a;
        if (a[1:0] != 2'b00) begin
            e.inst = 32'h0; e.fault = 1'b1; e.cause = 2'b01;
        end else if (d >= TO) begin
            e.inst = 32'h0; e.fault = 1'b1; e.cause = 2'b11;
        end else if (r != 2'b00) begin
            e.inst = 32'h0; e.fault = 1'b1; e.cause = 2'b10;
        end else begin
            e.inst = data; e.fault = 1'b0; e.cause = 2'b00;
        end
        return e;
    endfunction

    task automatic issue(input logic [31:0] a, input int d, input logic [1:0] r,
                         input logic [31:0] data, output int c0);
        plan_t p;
        int    n;
        exp_q.push_back(model(a, d, r, data));
        if (a[1:0] == 2'b00) begin
            p.addr = a; p.delay = d; p.resp = r; p.data = data;
            plan_q.push_back(p);
        end
        @(negedge clk);
        pc = a;
        pc_valid = 1'b1;
        n = 0;
        while (!pc_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        c0 = cyc;
        if (!pc_ready) begin
            checks++; errors++;
            $display("FAIL pc_accept: got no pc_ready expected accept of %h", a);
        end
        @(negedge clk);
        pc_valid = 1'b0;
        pc = $urandom;
    endtask

    // AXI slave model
    plan_t       pl;
    int          sph = 0;
    int          scnt = 0;
    bit          ar_seen = 0;
    logic [31:0] ar_hold;

    initial begin
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sph = 0; ar_seen = 0;
                arready = 1'b0; rvalid = 1'b0;
                continue;
            end
            if (sph == 2) begin
                rvalid = 1'b0;
                sph = 0;
            end
            if (sph == 0) begin
                if (arvalid) begin
                    if (ar_seen) chk("araddr_stable", 68'(araddr), 68'(ar_hold));
                    if (plan_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_arvalid: got araddr %h expected none", araddr);
                        arready = 1'b0;
                    end else begin
                        arready = fast ? 1'b1 : 1'($urandom_range(0, 1));
                        if (arready) begin
                            pl = plan_q.pop_front();
                            chk("araddr", 68'(araddr), 68'(pl.addr));
                            scnt = pl.delay;
                            sph = 1;
                            ar_seen = 0;
                        end else begin
                            ar_seen = 1;
                            ar_hold = araddr;
                        end
                    end
                end else begin
                    if (ar_seen) chk("arvalid_held", 68'(arvalid), 68'(1));
                    ar_seen = 0;
                    arready = 1'b0;
                end
            end else if (sph == 1) begin
                arready = 1'b0;
                if (scnt == 0) begin
                    rvalid = 1'b1;
                    rdata = pl.data;
                    rresp = pl.resp;
                    chk("rready_on_rvalid", 68'(rready), 68'(1));
                    sph = 2;
                end else begin
                    scnt--;
                    rvalid = 1'b0;
                    rdata = $urandom;
                    rresp = 2'($urandom_range(0, 3));
                end
            end
        end
    end

    // Decode-side monitor / scoreboard
    bit          held = 0;
    logic [66:0] held_v;

    initial begin
        inst_ready = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                held = 0;
                inst_ready = 1'b0;
                continue;
            end
            if (held)
                chk("out_stable", 68'({inst_valid, inst, inst_pc, fault, fault_cause}),
                    {1'b1, held_v});
            if (inst_valid) begin
                inst_ready = fast ? 1'b1 : 1'($urandom_range(0, 2) != 0);
                if (inst_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_inst: got pc %h expected none", inst_pc);
                    end else begin
                        chk("sb_item", 68'({inst, inst_pc, fault, fault_cause}),
                            68'(exp_q.pop_front()));
                    end
                    held = 0;
                end else begin
                    held = 1;
                    held_v = {inst, inst_pc, fault, fault_cause};
                end
            end else begin
                held = 0;
                inst_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || plan_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 68'(exp_q.size() + plan_q.size()), 68'(0));
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  r;
        int          d, k, c0, c1, n;
        rst = 1'b0; pc = 32'h0; pc_valid = 1'b0;
        #13;
        chk("rst_pc_ready", 68'(pc_ready), 68'(1));
        chk("rst_bus", 68'({arvalid, rready, araddr}), 68'(0));
        chk("rst_out", 68'({inst_valid, inst, inst_pc, fault, fault_cause}), 68'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 250; i++) begin
            k = $urandom_range(0, 9);
            a = 32'h8000_0000 + ($urandom_range(0, 1023) << 2);
            if (k == 0) a[1:0] = 2'($urandom_range(1, 3));
            if (k == 1) d = TO - 1;
            else if (k == 2) d = TO + $urandom_range(0, 6);
            else d = $urandom_range(0, TO - 2);
            r = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            issue(a, d, r, $urandom, c0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_empty("random_drain");

        issue(32'h8000_0100, 40, 2'b00, 32'hdead_beef, c0);
        n = 0;
        while (!rready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reach_rwait", 68'(rready), 68'(1));
        #2 rst = 1'b0;
        #1;
        chk("arst_pc_ready", 68'(pc_ready), 68'(1));
        chk("arst_bus", 68'({arvalid, rready, araddr}), 68'(0));
        chk("arst_out", 68'({inst_valid, inst, inst_pc, fault, fault_cause}), 68'(0));
        exp_q.delete();
        plan_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        fast = 1;

        issue(32'h8000_0000, 0, 2'b00, 32'h0000_0413, c0);
        n = 0;
        while (!inst_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 68'(cyc - c0), 68'(3));
        issue(32'h8000_0004, 0, 2'b00, 32'h0040_0093, c1);
        chk("next_pc_cycle", 68'(c1 - c0), 68'(4));
        wait_empty("fast_drain");

        issue(32'h8000_0002, 0, 2'b00, 32'h0, c0);
        n = 0;
        while (!inst_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("misaligned_latency", 68'(cyc - c0), 68'(1));
        wait_empty("final_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
